// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider producing {remainder, quotient}.
// One quotient bit per clock, then a restore step and a sign-fixup step.
module seq_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, SIGN} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   dmag;
  logic [CW-1:0]    count;
  logic             sign_q;
  logic             sign_r;
  logic             zero_div;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_step;

  // The most negative operand negates to itself, which read unsigned is 2^(WIDTH-1).
  assign neg_a = SIGNED ? dividend[WIDTH-1] : 1'b0;
  assign neg_b = SIGNED ? divisor[WIDTH-1]  : 1'b0;
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor  : divisor;

  // The new partial remainder is the restoring trial value, so its sign gives the quotient bit.
  assign rem_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign rem_step = rem[WIDTH] ? (rem_sh + dmag) : (rem_sh - dmag);

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result      <= '0;
      count       <= '0;
      rem         <= '0;
      quo         <= '0;
      dmag        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q      <= neg_a ^ neg_b;
            sign_r      <= neg_a;
            zero_div    <= (divisor == '0);
            // A zero divisor reports the raw dividend, so park it in the quotient register.
            quo         <= (divisor == '0) ? dividend : mag_a;
            dmag        <= {1'b0, mag_b};
            rem         <= '0;
            count       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state       <= ITER;
          end
        end
        ITER: begin
          if (zero_div) begin
            result      <= {quo, {WIDTH{1'b1}}};
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            rem   <= rem_step;
            quo   <= {quo[WIDTH-2:0], ~rem_step[WIDTH]};
            count <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          if (rem[WIDTH]) rem <= rem + dmag;
          state <= SIGN;
        end
        SIGN: begin
          result <= {(sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]),
                     (sign_q ? -quo : quo)};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a vector table for the signed instance plus
// hand-written handshake sequences and an unsigned instance.
module tb_seq_divider;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] result;

  logic        u_start;
  logic [31:0] u_dividend;
  logic [31:0] u_divisor;
  logic        u_busy;
  logic        u_done;
  logic        u_div_by_zero;
  logic [63:0] u_result;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(32), .SIGNED(1'b1)) u_dut (
    .clock(clock), .clear(clear), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .result(result)
  );

  seq_divider #(.WIDTH(32), .SIGNED(1'b0)) u_dut_unsigned (
    .clock(clock), .clear(clear), .start(u_start), .dividend(u_dividend),
    .divisor(u_divisor), .busy(u_busy), .done(u_done),
    .div_by_zero(u_div_by_zero), .result(u_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start; returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0000;
  endtask

  // Counts edges until done is seen (bounded); flags busy dropping early or staying high at done.
  task automatic waitDone(input int limit, output int lat, output logic busy_bad);
    lat      = 0;
    busy_bad = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      lat++;
      if (done) begin
        if (busy) busy_bad = 1'b1;
        break;
      end
      if (!busy) busy_bad = 1'b1;
      if (lat >= limit) break;
    end
  endtask

  initial begin
    int   lat;
    logic busy_bad;
    int   done_seen;

    vecs[0]  = '{"pos_div",      32'd17,        32'd5,         64'h00000002_00000003, 1'b0, 34};
    vecs[1]  = '{"neg_dividend", 32'hFFFFFFEF,  32'd5,         64'hFFFFFFFE_FFFFFFFD, 1'b0, 34};
    vecs[2]  = '{"neg_divisor",  32'd17,        32'hFFFFFFFB,  64'h00000002_FFFFFFFD, 1'b0, 34};
    vecs[3]  = '{"div_zero",     32'h12345678,  32'h00000000,  64'h12345678_FFFFFFFF, 1'b1, 1};
    vecs[4]  = '{"overflow",     32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 1'b0, 34};
    vecs[5]  = '{"hundred_7",    32'd100,       32'd7,         64'h00000002_0000000E, 1'b0, 34};
    vecs[6]  = '{"nine_3",       32'd9,         32'd3,         64'h00000000_00000003, 1'b0, 34};
    vecs[7]  = '{"zero_num",     32'd0,         32'd5,         64'h00000000_00000000, 1'b0, 34};
    vecs[8]  = '{"both_neg",     32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 1'b0, 34};
    vecs[9]  = '{"small_num",    32'd7,         32'd100,       64'h00000007_00000000, 1'b0, 34};
    vecs[10] = '{"max_pos_1",    32'h7FFFFFFF,  32'd1,         64'h00000000_7FFFFFFF, 1'b0, 34};
    vecs[11] = '{"m1_minint",    32'hFFFFFFFF,  32'h80000000,  64'hFFFFFFFF_00000000, 1'b0, 34};
    vecs[12] = '{"minint_2",     32'h80000000,  32'd2,         64'h00000000_C0000000, 1'b0, 34};

    clear      = 1'b1;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    u_start    = 1'b0;
    u_dividend = '0;
    u_divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_dbz", {63'd0, div_by_zero}, 64'd0);
    checkOutput("reset_result", result, 64'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, "_busy_acc"}, {63'd0, busy}, 64'd1);
      checkOutput({vecs[i].name, "_dbz_acc"}, {63'd0, div_by_zero}, 64'd0);
      waitDone(60, lat, busy_bad);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      checkOutput({vecs[i].name, "_busy"}, {63'd0, busy_bad}, 64'd0);
      checkOutput({vecs[i].name, "_result"}, result, vecs[i].res);
      checkOutput({vecs[i].name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, vecs[i].dbz});
      @(posedge clock);
      #1;
      checkOutput({vecs[i].name, "_done_pulse"}, {63'd0, done}, 64'd0);
      checkOutput({vecs[i].name, "_result_hold"}, result, vecs[i].res);
    end

    // A second start while busy must be dropped.
    applyStimulus(32'd100, 32'd7);
    repeat (9) @(posedge clock);
    @(negedge clock);
    dividend = 32'd50;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    waitDone(60, lat, busy_bad);
    checkOutput("ignore_latency", 64'(lat), 64'd24);
    checkOutput("ignore_result", result, 64'h00000002_0000000E);

    // Back-to-back: start issued while done is high is accepted.
    applyStimulus(32'd17, 32'd5);
    checkOutput("b2b_busy", {63'd0, busy}, 64'd1);
    waitDone(60, lat, busy_bad);
    checkOutput("b2b_latency", 64'(lat), 64'd34);
    checkOutput("b2b_result", result, 64'h00000002_00000003);

    // Clear mid-operation aborts without a done pulse.
    applyStimulus(32'd100, 32'd7);
    repeat (19) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_result", result, 64'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", 64'(done_seen), 64'd0);
    applyStimulus(32'd9, 32'd3);
    waitDone(60, lat, busy_bad);
    checkOutput("after_abort_latency", 64'(lat), 64'd34);
    checkOutput("after_abort_result", result, 64'h00000000_00000003);

    // Unsigned instance.
    for (int v = 0; v < 2; v++) begin
      logic [31:0] ua;
      logic [31:0] ub;
      logic [63:0] ures;
      int          ulat;
      ua   = (v == 0) ? 32'hFFFFFFFF : 32'h80000000;
      ub   = (v == 0) ? 32'd2        : 32'hFFFFFFFF;
      ures = (v == 0) ? 64'h00000001_7FFFFFFF : 64'h80000000_00000000;
      @(negedge clock);
      u_dividend = ua;
      u_divisor  = ub;
      u_start    = 1'b1;
      @(posedge clock);
      #1;
      u_start = 1'b0;
      ulat    = 0;
      while (!u_done && ulat < 60) begin
        @(posedge clock);
        #1;
        ulat++;
      end
      checkOutput($sformatf("unsigned%0d_latency", v), 64'(ulat), 64'd34);
      checkOutput($sformatf("unsigned%0d_result", v), u_result, ures);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
